// File: rtl/alu_pkg.sv
// Shared definitions for the ALU logic/shift execute stage.
//   - OP_* opcodes (3-bit) as carried on the OP port
//   - stage FSM state encodings (ST_IDLE / ST_BUSY / ST_FULL)
//   - default operand and shift-amount widths
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = 5;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOR   = 3'b011;
  localparam logic [2:0] OP_SLL   = 3'b100;
  localparam logic [2:0] OP_SRL   = 3'b101;
  localparam logic [2:0] OP_SRA   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  // IDLE: output empty, BUSY: iterative shift running, FULL: result held
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_logic_32.sv
// Combinational bitwise unit: AND / OR / XOR / NOR / PASSB.
//   a, b : operands, [0:WIDTH-1], bit 0 = MSB
//   op   : opcode (OP_*); shift opcodes produce 0 here, the stage handles them
//   y    : selected result
// OR and NOR share the or_32 instance; NOR is its inverted output.
module alu_logic_32
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic [2:0]       op,
  output logic [0:WIDTH-1] y
);

  logic [0:WIDTH-1] or_y;

  or_32 #(.W(WIDTH)) u_or (
    .a (a),
    .b (b),
    .y (or_y)
  );

  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = or_y;
      OP_XOR:   y = a ^ b;
      OP_NOR:   y = ~or_y;
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/or_32.sv
// Bitwise OR of two operand vectors.
//   a, b : operands, [0:W-1], bit 0 = MSB
//   y    : a | b
module or_32 #(
  parameter int W = 32
) (
  input  logic [0:W-1] a,
  input  logic [0:W-1] b,
  output logic [0:W-1] y
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign y[i] = a[i] | b[i];
  end

endmodule

// File: rtl/alu_logic_shift_stage.sv
// Registered ALU execute stage for the bitwise/shift datapath.
// Logic ops complete in one cycle; shifts run an iterative 1-bit-per-cycle
// shifter. The result and its zero flag are registered and offered to the
// writeback consumer over valid/ready.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (transfer = in_valid & in_ready)
//   A, B, OP            : operands [0:WIDTH-1] (bit 0 = MSB) and opcode;
//                         shifts take shamt from the low SHW bits of B
//   out_valid, out_ready: result handshake (transfer = out_valid & out_ready)
//   RESULT, ZERO        : registered result and RESULT==0 flag
module alu_logic_shift_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  input  logic [2:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] RESULT,
  output logic             ZERO
);

  state_t           state, state_nxt;
  logic             accept;
  logic             op_shift;
  logic             start_busy;
  logic             last_step;
  logic [SHW-1:0]   shamt;
  logic [SHW-1:0]   cnt;
  logic [0:WIDTH-1] shreg;
  logic [0:WIDTH-1] sh_step;
  logic [2:0]       sh_op;
  logic [0:WIDTH-1] logic_y;
  logic             ld_en;
  logic [0:WIDTH-1] ld_val;

  // Low SHW bits of B (bit 0 is the MSB, so they sit at the high indices).
  assign shamt      = B[WIDTH-SHW:WIDTH-1];
  assign accept     = in_valid & in_ready;
  assign op_shift   = is_shift(OP);
  assign start_busy = accept & op_shift & (shamt != '0);
  assign last_step  = (state == ST_BUSY) & (cnt == SHW'(1));

  alu_logic_32 #(.WIDTH(WIDTH)) u_logic (
    .a  (A),
    .b  (B),
    .op (OP),
    .y  (logic_y)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Handshake outputs are masked during reset so a pending result can't be
  // taken by the consumer in the cycle it is being discarded.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!reset) begin
      in_ready  = (state == ST_IDLE) | ((state == ST_FULL) & out_ready);
      out_valid = (state == ST_FULL);
    end
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = start_busy ? ST_BUSY : ST_FULL;
      end
      ST_BUSY: begin
        if (last_step) state_nxt = ST_FULL;
      end
      ST_FULL: begin
        // Drain and accept can coincide, keeping back-to-back logic ops at
        // one result per cycle.
        if (out_ready) begin
          if (accept) state_nxt = start_busy ? ST_BUSY : ST_FULL;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ shifter
  // SLL moves toward bit 0 (MSB); right shifts move toward WIDTH-1. The sign
  // bit never changes during SRA, so shreg[0] is still the original sign.
  always_comb begin
    sh_step = shreg;
    case (sh_op)
      OP_SLL:  sh_step = {shreg[1:WIDTH-1], 1'b0};
      OP_SRL:  sh_step = {1'b0, shreg[0:WIDTH-2]};
      OP_SRA:  sh_step = {shreg[0], shreg[0:WIDTH-2]};
      default: sh_step = shreg;
    endcase
  end

  // Result load select. A zero shift amount is a plain pass of A.
  always_comb begin
    ld_en  = 1'b0;
    ld_val = logic_y;
    if (accept && !start_busy) begin
      ld_en  = 1'b1;
      ld_val = op_shift ? A : logic_y;
    end else if (last_step) begin
      ld_en  = 1'b1;
      ld_val = sh_step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      cnt    <= '0;
      sh_op  <= OP_SLL;
      RESULT <= '0;
      ZERO   <= 1'b0;
    end else begin
      if (start_busy) begin
        shreg <= A;
        cnt   <= shamt;
        sh_op <= OP;
      end else if (state == ST_BUSY) begin
        shreg <= sh_step;
        cnt   <= cnt - SHW'(1);
      end
      // ZERO comes from the value being loaded, not the old RESULT.
      if (ld_en) begin
        RESULT <= ld_val;
        ZERO   <= ~|ld_val;
      end
    end
  end

endmodule
